// File: rtl/ex_mem_req.sv
// EX-stage data-SRAM request issuer: turns a load/store into one req/addr_ok request and
// filters data_ok responses of flushed instructions. Optional alignment check: MEM_REQ_ALE_EN.
module ex_mem_req #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             es_valid,
    input  logic             ms_allow_in,
    input  logic             flush,
    input  logic             ms_has_int,
    input  logic             es_mem_we,
    input  logic             es_mem_re,
    input  logic [1:0]       es_size,
    input  logic [31:0]      es_addr,
    input  logic [31:0]      es_st_data,
    output logic             es_mem_ready_go,
    output logic             es_ale,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    output logic             ms_data_ok,
    output logic [CNT_W-1:0] outstanding_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CANCEL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
    req_t             hold_q, hold_d;
    req_t             live_req;

    logic mem_op;
    logic ale;
    logic issue_ok;
    logic req_raw;
    logic ready_go;
    logic advance;
    logic accept;
    logic discard_inc;

    assign mem_op = es_valid & (es_mem_we | es_mem_re);

`ifdef MEM_REQ_ALE_EN
    assign ale = mem_op & (((es_size == 2'd1) & es_addr[0]) |
                           ((es_size == 2'd2) & (es_addr[1:0] != 2'b00)));
`else
    assign ale = 1'b0;
`endif

    assign issue_ok = mem_op & ~ale & ~ms_has_int & ~flush &
                      (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

    // Request payload built straight from the EX operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        live_req       = '0;
        live_req.wr    = es_mem_we;
        live_req.size  = es_size;
        live_req.addr  = es_addr;
        case (es_size)
            2'd0: begin
                live_req.wstrb = 4'b0001 << es_addr[1:0];
                live_req.wdata = {4{es_st_data[7:0]}};
            end
            2'd1: begin
                live_req.wstrb = es_addr[1] ? 4'b1100 : 4'b0011;
                live_req.wdata = {2{es_st_data[15:0]}};
            end
            default: begin
                live_req.wstrb = 4'b1111;
                live_req.wdata = es_st_data;
            end
        endcase
        if (!es_mem_we) live_req.wstrb = 4'b0000;
    end

    // A cancelled request stays on the bus while EX moves on, so its payload is frozen here.
    assign hold_d = (state_q == S_CANCEL) ? hold_q : live_req;

    assign req_raw = ((state_q == S_IDLE) & issue_ok) |
                     (state_q == S_REQ) | (state_q == S_CANCEL);
    assign accept  = req_raw & data_sram_addr_ok;

    always_comb begin
        ready_go = 1'b0;
        if (!mem_op || ale || ms_has_int) begin
            ready_go = 1'b1;
        end else begin
            case (state_q)
                S_IDLE:   ready_go = issue_ok & data_sram_addr_ok;
                S_REQ:    ready_go = data_sram_addr_ok;
                S_CANCEL: ready_go = 1'b0;
                S_DONE:   ready_go = 1'b1;
                default:  ready_go = 1'b0;
            endcase
        end
    end

    assign advance = es_valid & ready_go & ms_allow_in;

    always_comb begin
        state_d     = state_q;
        discard_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_ok) begin
                    if (data_sram_addr_ok) state_d = advance ? S_IDLE : S_DONE;
                    else                   state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (flush) begin
                        state_d     = S_IDLE;
                        discard_inc = 1'b1;
                    end else begin
                        state_d = advance ? S_IDLE : S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (data_sram_addr_ok) begin
                    state_d     = S_IDLE;
                    discard_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d     = S_IDLE;
                    discard_inc = 1'b1;
                end else if (advance) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Both counters saturate at zero so a stray data_ok cannot wrap them.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (accept && !data_sram_data_ok)
            out_cnt_d = out_cnt_q + 1'b1;
        else if (!accept && data_sram_data_ok && (out_cnt_q != '0))
            out_cnt_d = out_cnt_q - 1'b1;

        disc_cnt_d = disc_cnt_q;
        if (discard_inc && !(data_sram_data_ok && (disc_cnt_q != '0)))
            disc_cnt_d = disc_cnt_q + 1'b1;
        else if (!discard_inc && data_sram_data_ok && (disc_cnt_q != '0))
            disc_cnt_d = disc_cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    // NOTE: the payload hold register is pure datapath and is only read in CANCEL, so it has no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign es_mem_ready_go = ready_go;
    assign es_ale          = ale & ~reset;
    assign data_sram_req   = req_raw & ~reset;
    assign data_sram_wr    = (state_q == S_CANCEL) ? hold_q.wr    : live_req.wr;
    assign data_sram_size  = (state_q == S_CANCEL) ? hold_q.size  : live_req.size;
    assign data_sram_addr  = (state_q == S_CANCEL) ? hold_q.addr  : live_req.addr;
    assign data_sram_wstrb = (state_q == S_CANCEL) ? hold_q.wstrb : live_req.wstrb;
    assign data_sram_wdata = (state_q == S_CANCEL) ? hold_q.wdata : live_req.wdata;
    assign ms_data_ok      = data_sram_data_ok & (disc_cnt_q == '0) & ~reset;
    assign outstanding_cnt = out_cnt_q;

endmodule
